// File: rtl/serial_tx_feeder.sv
// serial_tx_feeder: byte FIFO that splits each byte into two nibbles for a busy-paced serial transmitter
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   byte_in    byte from producer, accepted when byte_valid && byte_ready
//   byte_ready FIFO not full (from registered count)
//   data_in    nibble to transmitter, 0 whenever valid_in is low
//   valid_in   nibble valid; taken on an edge with valid_in && !busy_out
//   busy_out   transmitter busy, stalls the current nibble
//   fifo_count bytes stored in the FIFO (0..DEPTH)
module serial_tx_feeder #(
   parameter int DEPTH     = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               byte_in,
   input  logic                     byte_valid,
   output logic                     byte_ready,
   output logic [3:0]               data_in,
   output logic                     valid_in,
   input  logic                     busy_out,
   output logic [$clog2(DEPTH):0]   fifo_count
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [2:0] {IDLE, FIRST, GAP1, SECOND, GAP2} state_t;
   state_t state, state_nx;
   logic [7:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;
   logic [7:0] cur;
   logic push, pop;
   logic [3:0] first_nib, second_nib;
   assign fifo_count = count;
   assign byte_ready = count != (AW+1)'(DEPTH);
   assign push = byte_valid && byte_ready;
   assign first_nib = LSB_FIRST ? cur[3:0] : cur[7:4];
   assign second_nib = LSB_FIRST ? cur[7:4] : cur[3:0];
   assign valid_in = state == FIRST || state == SECOND;
   assign data_in = state == FIRST ? first_nib : state == SECOND ? second_nib : 4'h0;
   // Pop decisions use the registered count, so a byte pushed into an empty FIFO waits one edge.
   always_comb begin
      state_nx = state;
      pop = 1'b0;
      case (state)
         IDLE: begin
            pop = count != '0;
            state_nx = pop ? FIRST : IDLE;
         end
         FIRST:  state_nx = busy_out ? FIRST : GAP1;
         GAP1:   state_nx = SECOND;
         SECOND: state_nx = busy_out ? SECOND : GAP2;
         GAP2: begin
            pop = count != '0;
            state_nx = pop ? FIRST : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         cur    <= '0;
      end else begin
         state <= state_nx;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            cur    <= mem[rd_ptr];
         end
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= byte_in;
   end
endmodule

// File: doc/serial_tx_feeder.md
# serial_tx_feeder

Byte-wide buffering and nibble-splitting stage that sits directly upstream of the serial transmitter and drives its `data_in`/`valid_in` inputs. The block accepts bytes over a valid/ready handshake into a FIFO, splits each byte into two 4-bit nibbles, and issues them one at a time. Issue is paced by the transmitter's `busy_out`. This lets producers push full bytes without tracking transmitter occupancy.

## Interface
- `DEPTH`, 8: FIFO depth in bytes; must be a power of two, ≥2.
- `LSB_FIRST`, 1: 1 sends the low nibble `[3:0]` first; 0 sends the high nibble `[7:4]` first.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `byte_in`  in  8  byte from producer.
- `byte_valid`  in  1  producer has `byte_in` valid.
- `byte_ready`  out  1  FIFO can accept; equals !full.
- `data_in`  out  4  nibble to transmitter.
- `valid_in`  out  1  nibble on `data_in` is valid.
- `busy_out`  in  1  transmitter busy; nibble is not taken while high.
- `fifo_count`  out  $clog2(DEPTH)+1  bytes currently stored (0..DEPTH).

## Operation
**Reset (`rst`=0, async):**
- FIFO pointers and `fifo_count` = 0.
- `byte_ready` = 1.
- `valid_in` = 0.
- `data_in` = 0.
- FSM goes to IDLE.
- Any byte in flight is discarded.

**FIFO:**
- Push when `byte_valid && byte_ready` at the clock edge.
- Pop only from the FSM (IDLE→FIRST, or SECOND-GAP→FIRST).
- Push and pop in the same edge is allowed: count unchanged, pointers wrap modulo DEPTH.
- `byte_ready` is derived from registered count. When full it stays 0 even if a pop occurs on that edge.
- A push into an empty FIFO cannot be popped on the same edge.

**Nibble transfer rule:**
- A nibble is taken on an edge where `valid_in && !busy_out`.
- The transmitter raises `busy_out` the cycle after it accepts.

**FSM states:**
- **IDLE:** `valid_in`=0. If `fifo_count`≠0, pop the head byte into the `cur` register → FIRST.
- **FIRST:** `valid_in`=1, `data_in` = first nibble of `cur`. On transfer → GAP1; otherwise hold with `data_in` stable.
- **GAP1:** `valid_in`=0 for exactly one cycle, so the same nibble is never issued twice → SECOND.
- **SECOND:** `valid_in`=1, `data_in` = other nibble. On transfer → GAP2; otherwise hold.
- **GAP2:** `valid_in`=0 for one cycle. If `fifo_count`≠0, pop → FIRST; else → IDLE.

**Outputs:**
- `data_in` and `valid_in` are decoded only from registered state and `cur`; no combinational path from `busy_out` or `byte_*`.
- `data_in` = 0 whenever `valid_in`=0.

## Timing
- Byte pushed into an empty FIFO at edge N: count=1 after N, pop at edge N+1, `valid_in`=1 during cycle N+2.
- Minimum per byte with `busy_out` held low: FIRST, GAP1, SECOND, GAP2 = 4 cycles. Back-to-back bytes sustain 4 cycles per byte.
- `busy_out` high during FIRST or SECOND stalls indefinitely; state, `data_in` and `cur` are held.
- `busy_out` during GAP cycles is ignored.
- `byte_ready` falls the cycle after the push that makes count = DEPTH. It rises the cycle after the first pop from full.
- Async reset mid-byte (any state): outputs go to reset values immediately, without waiting for a clock. After reset release, no partial nibble is ever re-sent.

## Test plan
- **Single byte, default order:**
  - Stimulus: reset, then push 0xA5 with `busy_out`=0, `LSB_FIRST`=1.
  - Required: `valid_in` pulses carry 0x5 then 0xA, separated by exactly one low cycle; first pulse 2 cycles after the push edge.
  - Repeat with `LSB_FIRST`=0: required order 0xA then 0x5.
- **Stall:**
  - Stimulus: push 0x3C, hold `busy_out`=1 for 10 cycles, then release.
  - Required: `valid_in`=1 and `data_in`=0xC stable for all 10 cycles. Transfer occurs on the first edge with `busy_out`=0, then 0x3 follows after the gap.
- **Fill and full:**
  - Stimulus: `busy_out`=1, push 0x00..0x08 continuously.
  - Required: one byte sits in `cur` and 8 are stored (`fifo_count`=8). `byte_ready`=0 afterwards, and the 10th byte is not accepted.
  - Release `busy_out`: nibbles come out in order 0,0,1,0,2,0,… with no loss or duplication.
- **Simultaneous push/pop at wrap:**
  - Stimulus: stream 20 bytes with `byte_valid` held high and `busy_out`=0.
  - Required: pointers wrap cleanly, count never exceeds DEPTH, and the output nibble sequence matches the input byte sequence exactly. Bytes sustain 4 cycles each.
- **Reset mid-operation:**
  - Stimulus: assert `rst`=0 asynchronously while in SECOND with 3 bytes queued.
  - Required: `valid_in`=0, `fifo_count`=0 and `byte_ready`=1 immediately. After release, no output appears until a new push.
